// File: rtl/lisnoc_pkg.sv
// Shared lisnoc definitions: flit layout, flit-type encoding and the
// link-arbiter FSM state type. The type field occupies the two MSBs of a flit.
package lisnoc_pkg;

    localparam int FLIT_DATA_WIDTH = 32;
    localparam int FLIT_TYPE_WIDTH = 2;
    localparam int FLIT_WIDTH_DEF  = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH;

    // Flit type encoding; the MSB of the type field marks the last flit of a packet.
    typedef enum logic [1:0] {
        FLIT_PAYLOAD = 2'b00,
        FLIT_HEADER  = 2'b01,
        FLIT_TAIL    = 2'b10,
        FLIT_SINGLE  = 2'b11
    } flit_type_t;

    // Output-link ownership state.
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Interpret the two type bits taken from the top of a flit.
    function automatic flit_type_t flit_type(input logic [1:0] type_bits);
        return flit_type_t'(type_bits);
    endfunction

    // TAIL and SINGLE both close a packet; they share type bit 1.
    function automatic logic flit_is_last(input logic [1:0] type_bits);
        return type_bits[1];
    endfunction

endpackage

// File: rtl/lisnoc_arb_rr.sv
// Stateless round-robin selector: one-hot grant to the first requester at or
// after prio_ptr, wrapping from PORTS-1 back to 0. All zeros if nobody requests.
module lisnoc_arb_rr #(
    parameter int PORTS = 4,
    parameter int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic [PORTS-1:0] req,
    input  logic [PTR_W-1:0] prio_ptr,
    output logic [PORTS-1:0] grant
);

    // sum is one bit wider than the pointer so ptr+i never overflows before the wrap.
    logic [PTR_W:0] sum;
    logic           found;

    // Scan PORTS candidates starting at prio_ptr; the first hit wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        for (int i = 0; i < PORTS; i++) begin
            sum = {1'b0, prio_ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(PORTS)) begin
                sum = sum - (PTR_W+1)'(PORTS);
            end
            if (!found && req[sum[PTR_W-1:0]]) begin
                grant[sum[PTR_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_link_arbiter.sv
// Packet-level round-robin arbiter for one tile NoC output link.
// A source that wins arbitration owns the link until it sends its last flit
// (TAIL or SINGLE); flits pass through a single output register that sustains
// one flit per cycle. PORTS is legal from 2 to 8.
//
// Handshake: every interface here is strict valid/ready. A transfer happens on
// a rising edge where valid and ready are both high; a valid source holds its
// flit stable until that edge, and ready never depends on the same port's valid.
module noc_link_arbiter
    import lisnoc_pkg::*;
#(
    parameter int FLIT_WIDTH = 34,
    parameter int PORTS      = 4
) (
    input  logic                        clk,
    input  logic                        rst_sys,
    input  logic [PORTS*FLIT_WIDTH-1:0] in_flit,
    input  logic [PORTS-1:0]            in_valid,
    output logic [PORTS-1:0]            in_ready,
    output logic [FLIT_WIDTH-1:0]       out_flit,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PORTS-1:0]            grant,
    output arb_state_t                  dbg_state
);

    localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    arb_state_t            state;
    logic [PTR_W-1:0]      prio_ptr;
    logic [PORTS-1:0]      rr_grant;
    logic [FLIT_WIDTH-1:0] sel_flit;
    logic [PTR_W-1:0]      grant_idx;
    logic [PTR_W-1:0]      next_ptr;
    logic                  out_free;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  sel_last;

    assign dbg_state = state;

    // Candidate winner for the next packet; only consulted while IDLE.
    lisnoc_arb_rr #(
        .PORTS (PORTS),
        .PTR_W (PTR_W)
    ) u_arb_rr (
        .req      (in_valid),
        .prio_ptr (prio_ptr),
        .grant    (rr_grant)
    );

    // The output register can take a new flit when empty or draining this cycle.
    assign out_free = ~out_valid | out_ready;
    assign out_xfer = out_valid & out_ready;

    // Only the link owner is offered ready, and only while LOCKED.
    always_comb begin
        in_ready = '0;
        if (state == ARB_LOCKED) begin
            in_ready = grant & {PORTS{out_free}};
        end
    end

    assign in_xfer = |(in_valid & in_ready);

    // Route the owner's flit (grant is one-hot or zero) and find its index.
    always_comb begin
        sel_flit  = '0;
        grant_idx = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant[i]) begin
                sel_flit  = sel_flit | in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
                grant_idx = PTR_W'(i);
            end
        end
    end

    assign sel_last = flit_is_last(sel_flit[FLIT_WIDTH-1 -: 2]);

    // After a packet the port just served gets lowest priority next round.
    always_comb begin
        if (grant_idx == PTR_W'(PORTS-1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_idx + PTR_W'(1);
        end
    end

    // Link ownership FSM: lock onto a winner, release on the last flit accepted.
    always_ff @(posedge clk) begin
        if (!rst_sys) begin
            state    <= ARB_IDLE;
            grant    <= '0;
            prio_ptr <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|in_valid) begin
                        grant <= rr_grant;
                        state <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (in_xfer && sel_last) begin
                        grant    <= '0;
                        prio_ptr <= next_ptr;
                        state    <= ARB_IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Output register: load on input transfer, empty on a bare output transfer,
    // otherwise hold (keeps the flit stable under back-pressure, also in IDLE).
    always_ff @(posedge clk) begin
        if (!rst_sys) begin
            out_valid <= 1'b0;
            out_flit  <= '0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_flit  <= sel_flit;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_noc_link_arbiter.sv
// Directed bench for noc_link_arbiter: a table of per-cycle vectors for the
// two-source arbitration case, then hand-written sequences for round-robin
// fairness, back-pressure stalls, mid-packet valid drops and mid-packet reset.
module tb_noc_link_arbiter;
    import lisnoc_pkg::*;

    localparam int FW = 34;
    localparam int NP = 4;

    logic              clk = 1'b0;
    logic              rst_sys;
    logic [NP*FW-1:0]  in_flit;
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     in_ready;
    logic [FW-1:0]     out_flit;
    logic              out_valid;
    logic              out_ready;
    logic [NP-1:0]     grant;
    arb_state_t        dbg_state;

    // Clock / reset
    always #5 clk = ~clk;

    noc_link_arbiter #(
        .FLIT_WIDTH (FW),
        .PORTS      (NP)
    ) dut (
        .clk       (clk),
        .rst_sys   (rst_sys),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant),
        .dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] mkf(input logic [1:0] t, input logic [31:0] d);
        return {t, d};
    endfunction

    function automatic int onehot_idx(input logic [NP-1:0] v);
        int r = -1;
        for (int i = 0; i < NP; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Table vectors: inputs for one cycle and the outputs expected in that cycle.
    typedef struct {
        logic [NP-1:0]    iv;
        logic [NP*FW-1:0] flits;
        logic             ordy;
        logic [NP-1:0]    e_grant;
        logic [NP-1:0]    e_ir;
        logic             e_ov;
        logic [FW-1:0]    e_flit;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mkv(input logic [NP-1:0] iv, input logic [FW-1:0] f0,
                                 input logic [FW-1:0] f2, input logic ordy,
                                 input logic [NP-1:0] eg, input logic [NP-1:0] eir,
                                 input logic eov, input logic [FW-1:0] ef);
        vec_t v;
        v.iv            = iv;
        v.flits         = '0;
        v.flits[0 +: FW]    = f0;
        v.flits[2*FW +: FW] = f2;
        v.ordy          = ordy;
        v.e_grant       = eg;
        v.e_ir          = eir;
        v.e_ov          = eov;
        v.e_flit        = ef;
        return v;
    endfunction

    // Source model and scoreboard
    logic [FW-1:0] src_mem [NP][8];
    int            src_head [NP];
    int            src_tail [NP];
    int            xfer_cnt [NP];
    logic [NP-1:0] src_en;
    logic          rst_drv;
    logic          ordy_drv;
    logic [FW-1:0] exp_q [$];
    logic [FW-1:0] out_log [$];

    logic [NP-1:0] cur_grant;
    logic [NP-1:0] cur_ir;
    logic          cur_ov;
    logic [FW-1:0] cur_flit;
    arb_state_t    cur_state;

    task automatic clear_src();
        for (int p = 0; p < NP; p++) begin
            src_head[p] = 0;
            src_tail[p] = 0;
            xfer_cnt[p] = 0;
        end
    endtask

    task automatic push_src(input int p, input logic [FW-1:0] f);
        src_mem[p][src_tail[p]] = f;
        src_tail[p]++;
    endtask

    // Driver: one clock cycle of source/sink activity plus scoreboard update.
    task automatic cycle();
        logic [FW-1:0] e;
        @(negedge clk);
        rst_sys   = rst_drv;
        out_ready = ordy_drv;
        for (int p = 0; p < NP; p++) begin
            if (src_en[p] && src_head[p] < src_tail[p]) begin
                in_valid[p]          = 1'b1;
                in_flit[p*FW +: FW]  = src_mem[p][src_head[p]];
            end else begin
                in_valid[p]          = 1'b0;
                in_flit[p*FW +: FW]  = '0;
            end
        end
        #1;
        cur_grant = grant;
        cur_ir    = in_ready;
        cur_ov    = out_valid;
        cur_flit  = out_flit;
        cur_state = dbg_state;
        if (rst_drv) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_extra: got flit %0h expected none", out_flit);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_order", out_flit, e);
                end
                out_log.push_back(out_flit);
            end
            for (int p = 0; p < NP; p++) begin
                if (in_valid[p] && in_ready[p]) begin
                    exp_q.push_back(src_mem[p][src_head[p]]);
                    src_head[p]++;
                    xfer_cnt[p]++;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_drv  = 1'b0;
        ordy_drv = 1'b1;
        src_en   = '0;
        clear_src();
        cycle();
        rst_drv = 1'b1;
        exp_q.delete();
        out_log.delete();
    endtask

    task automatic chk_log(input string name, input logic [FW-1:0] e0, input logic [FW-1:0] e1,
                           input logic [FW-1:0] e2, input logic [FW-1:0] e3, input int n);
        logic [FW-1:0] ex [4];
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        chk({name, "_count"}, 64'(out_log.size()), 64'(n));
        for (int k = 0; k < n; k++) begin
            if (k < out_log.size()) chk(name, out_log[k], ex[k]);
        end
    endtask

    int            glog [$];
    int            exp_order [5];
    logic [NP-1:0] prev_grant;

    initial begin
        in_valid  = '0;
        in_flit   = '0;
        out_ready = 1'b1;
        rst_sys   = 1'b0;
        rst_drv   = 1'b0;
        ordy_drv  = 1'b1;
        src_en    = '0;
        clear_src();

        // Reset state
        cycle();
        cycle();
        rst_drv = 1'b1;
        cycle();
        chk("rst_grant", cur_grant, 0);
        chk("rst_out_valid", cur_ov, 0);
        chk("rst_in_ready", cur_ir, 0);
        chk("rst_out_flit", cur_flit, 0);
        chk("rst_state", cur_state, ARB_IDLE);

        // Two sources, 3-flit packets, no back-pressure
        vecs[0] = mkv(4'b0101, mkf(2'b01, 32'hA0), mkf(2'b01, 32'hC0), 1'b1, 4'b0000, 4'b0000, 1'b0, '0);
        vecs[1] = mkv(4'b0101, mkf(2'b01, 32'hA0), mkf(2'b01, 32'hC0), 1'b1, 4'b0001, 4'b0001, 1'b0, '0);
        vecs[2] = mkv(4'b0101, mkf(2'b00, 32'hA1), mkf(2'b01, 32'hC0), 1'b1, 4'b0001, 4'b0001, 1'b1, mkf(2'b01, 32'hA0));
        vecs[3] = mkv(4'b0101, mkf(2'b10, 32'hA2), mkf(2'b01, 32'hC0), 1'b1, 4'b0001, 4'b0001, 1'b1, mkf(2'b00, 32'hA1));
        vecs[4] = mkv(4'b0100, '0,                 mkf(2'b01, 32'hC0), 1'b1, 4'b0000, 4'b0000, 1'b1, mkf(2'b10, 32'hA2));
        vecs[5] = mkv(4'b0100, '0,                 mkf(2'b01, 32'hC0), 1'b1, 4'b0100, 4'b0100, 1'b0, '0);
        vecs[6] = mkv(4'b0100, '0,                 mkf(2'b00, 32'hC1), 1'b1, 4'b0100, 4'b0100, 1'b1, mkf(2'b01, 32'hC0));
        vecs[7] = mkv(4'b0100, '0,                 mkf(2'b10, 32'hC2), 1'b1, 4'b0100, 4'b0100, 1'b1, mkf(2'b00, 32'hC1));
        vecs[8] = mkv(4'b0000, '0,                 '0,                 1'b1, 4'b0000, 4'b0000, 1'b1, mkf(2'b10, 32'hC2));
        vecs[9] = mkv(4'b0000, '0,                 '0,                 1'b1, 4'b0000, 4'b0000, 1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rst_sys   = 1'b1;
            in_valid  = vecs[i].iv;
            in_flit   = vecs[i].flits;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("tbl%0d_grant", i), grant, vecs[i].e_grant);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, vecs[i].e_ir);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, vecs[i].e_ov);
            if (vecs[i].e_ov) chk($sformatf("tbl%0d_out_flit", i), out_flit, vecs[i].e_flit);
        end

        // Round-robin fairness with all sources sending SINGLE flits
        do_reset();
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 3; k++) push_src(p, mkf(2'b11, 32'(32'h100 * p + k)));
        src_en     = 4'hF;
        prev_grant = '0;
        glog.delete();
        for (int ph = 0; ph < 30; ph++) begin
            cycle();
            if (ph == 7)
                for (int p = 0; p < NP; p++) chk($sformatf("rr_window_p%0d", p), 64'(xfer_cnt[p]), 1);
            if (cur_grant != 0 && prev_grant == 0) glog.push_back(onehot_idx(cur_grant));
            prev_grant = cur_grant;
        end
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
        chk("rr_grant_count", 64'(glog.size()), 12);
        for (int k = 0; k < 5; k++)
            chk($sformatf("rr_order%0d", k), 64'((k < glog.size()) ? glog[k] : -1), 64'(exp_order[k]));
        for (int p = 0; p < NP; p++) chk($sformatf("rr_total_p%0d", p), 64'(xfer_cnt[p]), 3);
        chk("rr_drained", 64'(exp_q.size()), 0);

        // Back-pressure stall on a 4-flit packet from port 1
        do_reset();
        push_src(1, mkf(2'b01, 32'h11));
        push_src(1, mkf(2'b00, 32'h12));
        push_src(1, mkf(2'b00, 32'h13));
        push_src(1, mkf(2'b10, 32'h14));
        src_en = 4'b0010;
        for (int ph = 0; ph < 12; ph++) begin
            ordy_drv = (ph >= 3 && ph <= 6) ? 1'b0 : 1'b1;
            cycle();
            if (ph >= 3 && ph <= 6) begin
                chk($sformatf("stall%0d_flit", ph), cur_flit, mkf(2'b00, 32'h12));
                chk($sformatf("stall%0d_valid", ph), cur_ov, 1);
                chk($sformatf("stall%0d_ready", ph), cur_ir[1], 0);
            end
        end
        chk_log("stall_log", mkf(2'b01, 32'h11), mkf(2'b00, 32'h12), mkf(2'b00, 32'h13), mkf(2'b10, 32'h14), 4);

        // Port 3 drops valid mid-packet while port 0 waits
        do_reset();
        push_src(3, mkf(2'b01, 32'h31));
        push_src(3, mkf(2'b00, 32'h32));
        push_src(3, mkf(2'b10, 32'h33));
        push_src(0, mkf(2'b11, 32'h01));
        for (int ph = 0; ph < 15; ph++) begin
            src_en[3] = !(ph >= 2 && ph <= 6);
            src_en[0] = (ph >= 2);
            cycle();
            if (ph >= 1 && ph <= 6) begin
                chk($sformatf("hold%0d_grant", ph), cur_grant, 4'b1000);
                chk($sformatf("hold%0d_ready0", ph), cur_ir[0], 0);
            end
            if (ph == 10) chk("hold_next_grant", cur_grant, 4'b0001);
        end
        chk_log("hold_log", mkf(2'b01, 32'h31), mkf(2'b00, 32'h32), mkf(2'b10, 32'h33), mkf(2'b11, 32'h01), 4);

        // Reset during the PAYLOAD of a port-2 packet
        do_reset();
        push_src(2, mkf(2'b01, 32'h21));
        push_src(2, mkf(2'b00, 32'h22));
        push_src(2, mkf(2'b10, 32'h23));
        src_en = 4'b0100;
        cycle();
        cycle();
        rst_drv = 1'b0;
        cycle();
        rst_drv = 1'b1;
        clear_src();
        exp_q.delete();
        out_log.delete();
        push_src(0, mkf(2'b11, 32'h0A));
        push_src(2, mkf(2'b11, 32'h2A));
        src_en = 4'b0101;
        cycle();
        chk("midrst_out_valid", cur_ov, 0);
        chk("midrst_grant", cur_grant, 0);
        chk("midrst_state", cur_state, ARB_IDLE);
        cycle();
        chk("midrst_first_grant", cur_grant, 4'b0001);
        for (int ph = 0; ph < 6; ph++) cycle();
        chk_log("midrst_log", mkf(2'b11, 32'h0A), mkf(2'b11, 32'h2A), '0, '0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_link_arbiter.md
NOC_LINK_ARBITER -- requirements
Module: noc_link_arbiter

Interface
REQ-001 Parameter FLIT_WIDTH, default 34, gives the flit width as 32 data bits plus 2 type bits in the MSBs.
REQ-002 Parameter PORTS, default 4, gives the number of packet sources sharing one tile NoC output link; the legal range is 2..8.
REQ-003 clk  input  1  is the single system clock; all logic SHALL be on its rising edge.
REQ-004 rst_sys  input  1  is the system reset, synchronous and active-low.
REQ-005 in_flit  input  PORTS*FLIT_WIDTH  carries the source flits; port i occupies slice [(i+1)*FLIT_WIDTH-1 : i*FLIT_WIDTH].
REQ-006 in_valid  input  PORTS  is the per-source flit-valid signal.
REQ-007 in_ready  output  PORTS  is the per-source flit accept; a transfer occurs when in_valid[i] and in_ready[i] are both high.
REQ-008 out_flit  output  FLIT_WIDTH  is the registered flit toward the mesh link.
REQ-009 out_valid  output  1  is the registered output-valid signal.
REQ-010 out_ready  input  1  is the mesh back-pressure; an output transfer occurs when out_valid and out_ready are both high.
REQ-011 grant  output  PORTS  is the one-hot owner of the link, or all zeros when idle.

Function
REQ-012 The flit type SHALL be bits [FLIT_WIDTH-1:FLIT_WIDTH-2], encoded as 01 HEADER, 00 PAYLOAD, 10 TAIL and 11 SINGLE; a flit is last when bit FLIT_WIDTH-1 = 1.
REQ-013 The FSM SHALL have exactly two states: IDLE and LOCKED.
REQ-014 In IDLE with any in_valid high, the arbiter SHALL register a one-hot grant to the first requesting port at or after prio_ptr (round-robin with wrap from PORTS-1 to 0), then enter LOCKED on the next cycle.
REQ-015 In IDLE, all in_ready bits SHALL be 0 and grant SHALL be 0.
REQ-016 In LOCKED, in_ready[g] SHALL be (~out_valid | out_ready) for the granted port g, and all other bits SHALL be 0.
REQ-017 An input transfer SHALL load out_flit and set out_valid on the next edge.
REQ-018 An output transfer with no simultaneous input transfer SHALL clear out_valid.
REQ-019 A simultaneous input and output transfer SHALL keep out_valid at 1 with the new flit, giving full throughput of one flit per cycle.
REQ-020 An input transfer of a last flit SHALL return the FSM to IDLE, clear grant and set prio_ptr to g+1 mod PORTS, all on the same edge.
REQ-021 The output register SHALL still drain in IDLE; re-arbitration in IDLE does not wait for out_valid to clear.
REQ-022 Latency: a request in IDLE at cycle 0 produces the grant at cycle 1, the first in_ready at cycle 1, and out_valid at cycle 2.
REQ-023 A granted port dropping in_valid mid-packet SHALL keep the lock; no other port is served until that port sends its last flit.
REQ-024 A SINGLE flit SHALL occupy the lock for exactly one input transfer.
REQ-025 With no requests, prio_ptr SHALL hold its value.
REQ-026 A flit held in out_flit SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-027 With rst_sys=0 at a clock edge, the block SHALL set state=IDLE, prio_ptr=0, grant=0, out_valid=0, out_flit=0 and in_ready=0.
REQ-028 Reset asserted mid-packet SHALL discard the buffered flit and the lock; the first arbitration after release SHALL start from port 0.

Structure
REQ-029 The flit-type constants and the type/last extraction SHALL live in the shared lisnoc definitions package, alongside the existing flit definitions.
REQ-030 The round-robin selection SHALL be one sub-module, lisnoc_arb_rr (inputs: request vector and prio_ptr; output: one-hot grant), with no internal state.
REQ-031 The FSM, prio_ptr and the output register SHALL reside in noc_link_arbiter.

Verification
REQ-032 Ports 0 and 2 each request at cycle 0 with 3-flit packets (HEADER, PAYLOAD, TAIL), out_ready=1 -> grant=0001 at cycle 1, out_valid at cycles 2-4, grant=0100 at cycle 5, port-2 flits out at cycles 6-8.
REQ-033 All 4 ports continuously send SINGLE flits -> grant order 0,1,2,3,0 and exactly one flit per port per 8 cycles.
REQ-034 Port 1 sends a 4-flit packet with out_ready held 0 for cycles 3-6 -> out_flit stable, in_ready[1]=0 during the stall, no flit lost or duplicated, order preserved.
REQ-035 Port 3 deasserts in_valid for 5 cycles after its HEADER while port 0 requests -> grant stays 1000 and port 0 is not served until port 3's TAIL.
REQ-036 rst_sys=0 for 1 cycle during the PAYLOAD of a port-2 packet -> next cycle out_valid=0 and grant=0; with ports 0 and 2 requesting afterwards, port 0 is granted first.
